// File: rtl/rgbd_stream_sched_pkg.sv
// Shared widths, scheduler state encoding and config helpers for the RGB-D frame scheduler.
package rgbd_stream_sched_pkg;
  localparam int FRAME_ADDR_BW   = 19;
  localparam int H_SIZE_BW       = 10;
  localparam int V_SIZE_BW       = 9;
  localparam int SCHED_HBLANK_BW = 8;
  localparam int LINE_CNT_BW     = H_SIZE_BW + 1;

  typedef enum logic [2:0] {
    SCH_IDLE,
    SCH_LEAD,
    SCH_BOTH,
    SCH_TAIL0,
    SCH_FLUSH
  } sched_state_t;

  function automatic logic [V_SIZE_BW-1:0] clamp_lead(input logic [V_SIZE_BW-1:0] lead,
                                                      input logic [V_SIZE_BW-1:0] vsize);
    return (lead > vsize) ? vsize : lead;
  endfunction
endpackage

// File: rtl/rgbd_stream_sched_if.sv
// Control/config inputs and the two raster read streams of the frame scheduler.
interface rgbd_stream_sched_if
  import rgbd_stream_sched_pkg::*;
#(
  parameter int ADDR_BW = FRAME_ADDR_BW
);
  logic                       i_start;
  logic                       i_abort;
  logic [H_SIZE_BW-1:0]       r_hsize;
  logic [V_SIZE_BW-1:0]       r_vsize;
  logic [SCHED_HBLANK_BW-1:0] r_hblank;
  logic [V_SIZE_BW-1:0]       r_lead_lines;
  logic                       o_rd_en1;
  logic [ADDR_BW-1:0]         o_rd_addr1;
  logic                       o_rd_en0;
  logic [ADDR_BW-1:0]         o_rd_addr0;
  logic                       o_valid1;
  logic                       o_valid0;
  logic                       o_frame_start;
  logic                       o_frame_end;
  logic                       o_busy;

  modport master (
    output i_start, i_abort, r_hsize, r_vsize, r_hblank, r_lead_lines,
    input  o_rd_en1, o_rd_addr1, o_rd_en0, o_rd_addr0,
    input  o_valid1, o_valid0, o_frame_start, o_frame_end, o_busy
  );

  modport slave (
    input  i_start, i_abort, r_hsize, r_vsize, r_hblank, r_lead_lines,
    output o_rd_en1, o_rd_addr1, o_rd_en0, o_rd_addr0,
    output o_valid1, o_valid0, o_frame_start, o_frame_end, o_busy
  );
endinterface

// File: rtl/rgbd_stream_sched_raster_addr_gen.sv
// One raster read stream: hsize active cycles then hblank idle cycles per line, vsize lines.
// Registered outputs; first rd_en appears the cycle after go; no trailing blank is visible on rd_en.
module raster_addr_gen
  import rgbd_stream_sched_pkg::*;
#(
  parameter int ADDR_BW = FRAME_ADDR_BW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       go,
  input  logic                       clr,
  input  logic [H_SIZE_BW-1:0]       hsize,
  input  logic [SCHED_HBLANK_BW-1:0] hblank,
  input  logic [V_SIZE_BW-1:0]       vsize,
  output logic                       rd_en,
  output logic [ADDR_BW-1:0]         addr,
  output logic [LINE_CNT_BW-1:0]     x,
  output logic [V_SIZE_BW-1:0]       y,
  output logic                       last
);
  logic                   run;
  logic [ADDR_BW-1:0]     base;
  logic [LINE_CNT_BW-1:0] htot;
  logic [LINE_CNT_BW-1:0] x_nxt;
  logic                   line_end;
  logic                   frame_done;
  logic                   nxt_active;

  // x is the line phase: values >= hsize are the blank count of the line.
  assign htot       = LINE_CNT_BW'(hsize) + LINE_CNT_BW'(hblank);
  assign x_nxt      = x + LINE_CNT_BW'(1);
  assign line_end   = (x == htot - LINE_CNT_BW'(1));
  assign frame_done = line_end && (y == vsize - V_SIZE_BW'(1));
  assign nxt_active = (x_nxt < LINE_CNT_BW'(hsize));
  assign last       = rd_en && (x == LINE_CNT_BW'(hsize) - LINE_CNT_BW'(1))
                            && (y == vsize - V_SIZE_BW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      rd_en <= 1'b0;
      addr  <= '0;
      base  <= '0;
      x     <= '0;
      y     <= '0;
    end else if (clr) begin
      run   <= 1'b0;
      rd_en <= 1'b0;
      addr  <= '0;
      base  <= '0;
      x     <= '0;
      y     <= '0;
    end else if (go) begin
      run   <= 1'b1;
      rd_en <= 1'b1;
      addr  <= '0;
      base  <= '0;
      x     <= '0;
      y     <= '0;
    end else if (run) begin
      // The last line still counts its blank internally so the lead compare can see it.
      if (frame_done) begin
        run   <= 1'b0;
        rd_en <= 1'b0;
        x     <= '0;
        y     <= '0;
      end else if (line_end) begin
        x     <= '0;
        y     <= y + V_SIZE_BW'(1);
        base  <= base + ADDR_BW'(hsize);
        addr  <= base + ADDR_BW'(hsize);
        rd_en <= 1'b1;
      end else begin
        x     <= x_nxt;
        rd_en <= nxt_active;
        if (nxt_active) addr <= addr + ADDR_BW'(1);
      end
    end
  end
endmodule

// File: rtl/rgbd_stream_sched.sv
// Frame scheduler: reference stream1 leads current stream0 by `lead` lines; valids trail rd_en by RD_LAT.
// frame_start with the first stream1 read; frame_end one cycle after the last stream0 valid.
module rgbd_stream_sched
  import rgbd_stream_sched_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int ADDR_BW = FRAME_ADDR_BW
) (
  input logic                clk,
  input logic                rst_n,
  rgbd_stream_sched_if.slave bus
);
  localparam logic [1:0] FLUSH_LAST = 2'(RD_LAT - 1);

  sched_state_t               state;
  logic [H_SIZE_BW-1:0]       hsize_q;
  logic [V_SIZE_BW-1:0]       vsize_q;
  logic [SCHED_HBLANK_BW-1:0] hblank_q;
  logic [V_SIZE_BW-1:0]       lead_q;
  logic [V_SIZE_BW-1:0]       lead_in;
  logic [LINE_CNT_BW-1:0]     htot;
  logic [1:0]                 flush_cnt;
  logic                       frame_start_q, frame_end_q, busy_q;
  logic                       accept, lead_hit, go1, go0;
  logic                       rd_en1, rd_en0, last1, last0;
  logic [ADDR_BW-1:0]         addr1, addr0;
  logic [LINE_CNT_BW-1:0]     x1, x0;
  logic [V_SIZE_BW-1:0]       y1, y0;
  logic [RD_LAT-1:0]          vpipe1, vpipe0;

  assign lead_in  = clamp_lead(bus.r_lead_lines, bus.r_vsize);
  assign htot     = LINE_CNT_BW'(hsize_q) + LINE_CNT_BW'(hblank_q);
  assign accept   = (state == SCH_IDLE) && bus.i_start && !bus.i_abort;
  // Stream1 is on the final cycle of line lead-1, so it begins line `lead` next cycle.
  assign lead_hit = (state == SCH_LEAD) && (x1 == htot - LINE_CNT_BW'(1))
                                        && (y1 == lead_q - V_SIZE_BW'(1));
  assign go1      = accept;
  assign go0      = (accept && (lead_in == '0)) || lead_hit;

  raster_addr_gen #(.ADDR_BW(ADDR_BW)) u_gen1 (
    .clk(clk), .rst_n(rst_n), .go(go1), .clr(bus.i_abort),
    .hsize(hsize_q), .hblank(hblank_q), .vsize(vsize_q),
    .rd_en(rd_en1), .addr(addr1), .x(x1), .y(y1), .last(last1)
  );

  raster_addr_gen #(.ADDR_BW(ADDR_BW)) u_gen0 (
    .clk(clk), .rst_n(rst_n), .go(go0), .clr(bus.i_abort),
    .hsize(hsize_q), .hblank(hblank_q), .vsize(vsize_q),
    .rd_en(rd_en0), .addr(addr0), .x(x0), .y(y0), .last(last0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SCH_IDLE;
      hsize_q       <= '0;
      vsize_q       <= '0;
      hblank_q      <= '0;
      lead_q        <= '0;
      flush_cnt     <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      if (bus.i_abort) begin
        state     <= SCH_IDLE;
        busy_q    <= 1'b0;
        flush_cnt <= '0;
      end else begin
        case (state)
          SCH_IDLE: if (bus.i_start) begin
            hsize_q       <= bus.r_hsize;
            vsize_q       <= bus.r_vsize;
            hblank_q      <= bus.r_hblank;
            lead_q        <= lead_in;
            state         <= (lead_in == '0) ? SCH_BOTH : SCH_LEAD;
            frame_start_q <= 1'b1;
            busy_q        <= 1'b1;
          end
          SCH_LEAD: if (lead_hit) state <= (lead_q == vsize_q) ? SCH_TAIL0 : SCH_BOTH;
          SCH_BOTH: begin
            if (last0)      state <= SCH_FLUSH;
            else if (last1) state <= SCH_TAIL0;
          end
          SCH_TAIL0: if (last0) state <= SCH_FLUSH;
          SCH_FLUSH: begin
            if (flush_cnt == FLUSH_LAST) begin
              state       <= SCH_IDLE;
              frame_end_q <= 1'b1;
              busy_q      <= 1'b0;
              flush_cnt   <= '0;
            end else begin
              flush_cnt <= flush_cnt + 2'd1;
            end
          end
          default: state <= SCH_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe1 <= '0;
      vpipe0 <= '0;
    end else if (bus.i_abort) begin
      vpipe1 <= '0;
      vpipe0 <= '0;
    end else begin
      vpipe1[0] <= rd_en1;
      vpipe0[0] <= rd_en0;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe1[i] <= vpipe1[i-1];
        vpipe0[i] <= vpipe0[i-1];
      end
    end
  end

  // Stream0 stays parked while stream1 fills the lead lines.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state == SCH_LEAD) |-> (!rd_en0 && (x0 == '0) && (y0 == '0)));

  assign bus.o_rd_en1      = rd_en1;
  assign bus.o_rd_addr1    = addr1;
  assign bus.o_rd_en0      = rd_en0;
  assign bus.o_rd_addr0    = addr0;
  assign bus.o_valid1      = vpipe1[RD_LAT-1];
  assign bus.o_valid0      = vpipe0[RD_LAT-1];
  assign bus.o_frame_start = frame_start_q;
  assign bus.o_frame_end   = frame_end_q;
  assign bus.o_busy        = busy_q;
endmodule

// File: tb/tb_rgbd_stream_sched.sv
// Directed bench for rgbd_stream_sched: a RD_LAT=1 and a RD_LAT=3 instance driven in lockstep.
module tb_rgbd_stream_sched;
  import rgbd_stream_sched_pkg::*;

  typedef struct {
    int hsize;
    int vsize;
    int hblank;
    int lead;
    int lead_eff;
    int fend;
    int fend3;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs [5];

  rgbd_stream_sched_if bus ();
  rgbd_stream_sched_if bus3 ();

  assign bus3.i_start      = bus.i_start;
  assign bus3.i_abort      = bus.i_abort;
  assign bus3.r_hsize      = bus.r_hsize;
  assign bus3.r_vsize      = bus.r_vsize;
  assign bus3.r_hblank     = bus.r_hblank;
  assign bus3.r_lead_lines = bus.r_lead_lines;

  rgbd_stream_sched #(.RD_LAT(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  rgbd_stream_sched #(.RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    bus.r_hsize      = H_SIZE_BW'(v.hsize);
    bus.r_vsize      = V_SIZE_BW'(v.vsize);
    bus.r_hblank     = SCHED_HBLANK_BW'(v.hblank);
    bus.r_lead_lines = V_SIZE_BW'(v.lead);
  endtask

  // Reference raster: stream whose first active cycle is `first`.
  function automatic bit s_en(input vec_t v, input int c, input int first);
    int t, htot;
    htot = v.hsize + v.hblank;
    t = c - first;
    if (t < 0) return 1'b0;
    return ((t / htot) < v.vsize) && ((t % htot) < v.hsize);
  endfunction

  function automatic int s_addr(input vec_t v, input int c, input int first);
    int t, htot;
    htot = v.hsize + v.hblank;
    t = c - first;
    return (t / htot) * v.hsize + (t % htot);
  endfunction

  task automatic check_cycle(input vec_t v, input int c);
    int f0;
    bit e1, e0;
    f0 = 1 + v.lead_eff * (v.hsize + v.hblank);
    e1 = s_en(v, c, 1);
    e0 = s_en(v, c, f0);
    chk("rd_en1", c, 32'(bus.o_rd_en1), 32'(e1));
    chk("rd_en0", c, 32'(bus.o_rd_en0), 32'(e0));
    if (e1) chk("rd_addr1", c, 32'(bus.o_rd_addr1), 32'(s_addr(v, c, 1)));
    if (e0) chk("rd_addr0", c, 32'(bus.o_rd_addr0), 32'(s_addr(v, c, f0)));
    chk("valid1", c, 32'(bus.o_valid1), 32'(s_en(v, c, 2)));
    chk("valid0", c, 32'(bus.o_valid0), 32'(s_en(v, c, f0 + 1)));
    chk("valid1_lat3", c, 32'(bus3.o_valid1), 32'(s_en(v, c, 4)));
    chk("valid0_lat3", c, 32'(bus3.o_valid0), 32'(s_en(v, c, f0 + 3)));
    chk("frame_start", c, 32'(bus.o_frame_start), 32'(c == 1));
    chk("frame_end", c, 32'(bus.o_frame_end), 32'(c == v.fend));
    chk("frame_end_lat3", c, 32'(bus3.o_frame_end), 32'(c == v.fend3));
    chk("busy", c, 32'(bus.o_busy), 32'(c < v.fend));
    chk("busy_lat3", c, 32'(bus3.o_busy), 32'(c < v.fend3));
  endtask

  task automatic run_vec(input vec_t v);
    set_cfg(v);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int c = 1; c <= v.fend3 + 1; c++) begin
      check_cycle(v, c);
      tick();
    end
  endtask

  task automatic chk_idle(input int c);
    chk("idle_rd_en1", c, 32'(bus.o_rd_en1), 32'd0);
    chk("idle_rd_en0", c, 32'(bus.o_rd_en0), 32'd0);
    chk("idle_rd_addr1", c, 32'(bus.o_rd_addr1), 32'd0);
    chk("idle_rd_addr0", c, 32'(bus.o_rd_addr0), 32'd0);
    chk("idle_valid1", c, 32'(bus.o_valid1), 32'd0);
    chk("idle_valid0", c, 32'(bus.o_valid0), 32'd0);
    chk("idle_frame_start", c, 32'(bus.o_frame_start), 32'd0);
    chk("idle_frame_end", c, 32'(bus.o_frame_end), 32'd0);
    chk("idle_busy", c, 32'(bus.o_busy), 32'd0);
    chk("idle_valid0_lat3", c, 32'(bus3.o_valid0), 32'd0);
    chk("idle_busy_lat3", c, 32'(bus3.o_busy), 32'd0);
  endtask

  initial begin
    int fe_cyc;
    checks   = 0;
    failures = 0;
    //          hsize vsize hblank lead eff fend fend3
    vecs[0] = '{8, 4, 2, 2, 2, 60, 62};
    vecs[1] = '{8, 4, 2, 0, 0, 40, 42};
    vecs[2] = '{8, 4, 2, 9, 4, 80, 82};
    vecs[3] = '{5, 3, 1, 1, 1, 25, 27};
    vecs[4] = '{2, 1, 1, 1, 1, 7, 9};

    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    set_cfg(vecs[0]);
    #3;
    chk_idle(0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort in BOTH, then restart.
    set_cfg(vecs[0]);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (24) tick();
    chk("both_before_abort", 25, 32'(bus.o_rd_en0), 32'd1);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("abort_rd_en1", 26, 32'(bus.o_rd_en1), 32'd0);
    chk("abort_rd_en0", 26, 32'(bus.o_rd_en0), 32'd0);
    chk("abort_valid1", 26, 32'(bus.o_valid1), 32'd0);
    chk("abort_valid0", 26, 32'(bus.o_valid0), 32'd0);
    chk("abort_valid0_lat3", 26, 32'(bus3.o_valid0), 32'd0);
    chk("abort_busy", 26, 32'(bus.o_busy), 32'd0);
    chk("abort_frame_end", 26, 32'(bus.o_frame_end), 32'd0);
    tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("restart_rd_en1", 28, 32'(bus.o_rd_en1), 32'd1);
    chk("restart_addr1", 28, 32'(bus.o_rd_addr1), 32'd0);
    chk("restart_frame_start", 28, 32'(bus.o_frame_start), 32'd1);
    chk("restart_busy", 28, 32'(bus.o_busy), 32'd1);
    fe_cyc = -1;
    for (int c = 28; c <= 100; c++) begin
      if (bus.o_frame_end && fe_cyc < 0) fe_cyc = c;
      tick();
    end
    chk("restart_frame_end_cycle", 0, 32'(fe_cyc), 32'd87);

    // Start and abort together in IDLE: abort wins.
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    chk("start_abort_busy", 1, 32'(bus.o_busy), 32'd0);
    chk("start_abort_rd_en1", 1, 32'(bus.o_rd_en1), 32'd0);
    chk("start_abort_frame_start", 1, 32'(bus.o_frame_start), 32'd0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("start_after_busy", 2, 32'(bus.o_busy), 32'd1);
    chk("start_after_rd_en1", 2, 32'(bus.o_rd_en1), 32'd1);
    chk("start_after_frame_start", 2, 32'(bus.o_frame_start), 32'd1);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("lead_abort_busy", 3, 32'(bus.o_busy), 32'd0);
    chk("lead_abort_rd_en1", 3, 32'(bus.o_rd_en1), 32'd0);
    tick();

    // Second start ignored while busy, then asynchronous reset mid-frame.
    set_cfg(vecs[0]);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int c = 1; c <= 29; c++) begin
      check_cycle(vecs[0], c);
      bus.i_start = (c == 10);
      tick();
    end
    bus.i_start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle(30);
    tick();
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
